led_pattern_seq: RTL and testbench

- Downstream consumer of the free-running blink counter. Takes one slow counter bit as a step rate and drives the LED bank with a selectable pattern.
- Patterns: binary count, bounce scan, fill/drain, or hold.
- Sits between the counter stage and the top-level LED pins, replacing the direct counter-bit-to-LED assignment.

---
 rtl/led_pattern_seq.sv | 174 +++++++++++++++++
 tb/tb_led_pattern_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps a binary, bounce, fill/drain or hold pattern on each rising edge of rate_bit.
// Optional macro LED_PWM_EN adds a 3-bit brightness input that PWM-gates the LED outputs.
module led_pattern_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rate_bit,
    input  logic [1:0]       mode,
    input  logic             pause,
`ifdef LED_PWM_EN
    input  logic [2:0]       brightness,
`endif
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse,
    output logic             dir
);

    localparam logic [1:0] MODE_BIN    = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic             rate_q_r;
    logic [1:0]       mode_q_r;
    logic [WIDTH-1:0] pattern_r;
    logic             dir_r;
    logic             step_pulse_r;

    logic             step_s;
    logic             update_s;
    logic [1:0]       mode_nxt_s;
    logic [WIDTH-1:0] pattern_nxt_s;
    logic             dir_nxt_s;
    logic [WIDTH-1:0] fill_up_s;
    logic [WIDTH-1:0] fill_dn_s;

    assign step_s    = rate_bit & ~rate_q_r & ~pause;
    assign fill_up_s = {pattern_r[WIDTH-2:0], 1'b1};
    assign fill_dn_s = {pattern_r[WIDTH-2:0], 1'b0};

    // State register: edge detector, mode, pattern, direction and the update strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q_r     <= rate_bit;
            mode_q_r     <= MODE_BIN;
            pattern_r    <= {WIDTH{1'b0}};
            dir_r        <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            rate_q_r     <= rate_bit;
            mode_q_r     <= mode_nxt_s;
            pattern_r    <= pattern_nxt_s;
            dir_r        <= dir_nxt_s;
            step_pulse_r <= update_s;
        end
    end

    // Next-state logic: a mode change reloads the pattern, otherwise the current mode advances.
    always_comb begin
        mode_nxt_s    = mode_q_r;
        pattern_nxt_s = pattern_r;
        dir_nxt_s     = dir_r;
        update_s      = 1'b0;
        if (step_s) begin
            if (mode != mode_q_r) begin
                mode_nxt_s = mode;
                case (mode)
                    MODE_BIN: begin
                        pattern_nxt_s = {WIDTH{1'b0}};
                        dir_nxt_s     = 1'b0;
                        update_s      = 1'b1;
                    end
                    MODE_BOUNCE: begin
                        pattern_nxt_s = {{(WIDTH-1){1'b0}}, 1'b1};
                        dir_nxt_s     = 1'b0;
                        update_s      = 1'b1;
                    end
                    MODE_FILL: begin
                        pattern_nxt_s = {WIDTH{1'b0}};
                        dir_nxt_s     = 1'b0;
                        update_s      = 1'b1;
                    end
                    MODE_HOLD: begin
                        update_s = 1'b0;
                    end
                    default: begin
                        update_s = 1'b0;
                    end
                endcase
            end else begin
                case (mode_q_r)
                    MODE_BIN: begin
                        pattern_nxt_s = pattern_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        update_s      = 1'b1;
                    end
                    MODE_BOUNCE: begin
                        update_s = 1'b1;
                        // Turn around on the same step that reaches past an end, so there is no dwell.
                        if (!dir_r) begin
                            if (pattern_r[WIDTH-1]) begin
                                dir_nxt_s     = 1'b1;
                                pattern_nxt_s = pattern_r >> 1;
                            end else begin
                                pattern_nxt_s = pattern_r << 1;
                            end
                        end else begin
                            if (pattern_r[0]) begin
                                dir_nxt_s     = 1'b0;
                                pattern_nxt_s = pattern_r << 1;
                            end else begin
                                pattern_nxt_s = pattern_r >> 1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        update_s = 1'b1;
                        if (!dir_r) begin
                            pattern_nxt_s = fill_up_s;
                            if (&fill_up_s) begin
                                dir_nxt_s = 1'b1;
                            end else begin
                                dir_nxt_s = 1'b0;
                            end
                        end else begin
                            pattern_nxt_s = fill_dn_s;
                            if (fill_dn_s == {WIDTH{1'b0}}) begin
                                dir_nxt_s = 1'b0;
                            end else begin
                                dir_nxt_s = 1'b1;
                            end
                        end
                    end
                    MODE_HOLD: begin
                        update_s = 1'b0;
                    end
                    default: begin
                        update_s = 1'b0;
                    end
                endcase
            end
        end else begin
            update_s = 1'b0;
        end
    end

`ifdef LED_PWM_EN
    logic [2:0] pwm_cnt_r;

    // Free-running PWM phase counter, wraps 7 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_r <= 3'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 3'd1;
        end
    end

    // Output logic: LEDs gated on for (brightness+1) of every 8 cycles.
    always_comb begin
        leds       = pattern_r & {WIDTH{(pwm_cnt_r <= brightness)}};
        step_pulse = step_pulse_r;
        dir        = dir_r;
    end
`else
    // Output logic: LEDs follow the pattern register directly.
    always_comb begin
        leds       = pattern_r;
        step_pulse = step_pulse_r;
        dir        = dir_r;
    end
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed pattern walks plus randomized stimulus against a step-count model.
module tb_led_pattern_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rate_bit = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         pause = 1'b0;
    logic [W-1:0] leds;
    logic         step_pulse;
    logic         dir;
`ifdef LED_PWM_EN
    logic [2:0]   brightness = 3'd7;
    int           m_pwm;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: mode, steps since the last reload, and current expected outputs.
    int           m_mode;
    int           m_k;
    logic         m_prev;
    logic [W-1:0] m_pat;
    logic         m_dir;
    logic         m_pulse;

    led_pattern_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .rate_bit(rate_bit),
        .mode(mode),
        .pause(pause),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .leds(leds),
        .step_pulse(step_pulse),
        .dir(dir)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_pat(int md, int k);
        int m;
        int pos;
        logic [W-1:0] one;
        one = 1;
        case (md)
            0: return W'(k % (1 << W));
            1: begin
                m   = k % (2 * (W - 1));
                pos = (m <= W - 1) ? m : 2 * (W - 1) - m;
                return one << pos;
            end
            2: begin
                m = k % (2 * W);
                if (m <= W) return W'((1 << m) - 1);
                else        return W'(((1 << W) - 1) << (m - W));
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic model_dir(int md, int k);
        int m;
        case (md)
            1: begin
                m = k % (2 * (W - 1));
                return (m > W - 1) || (m == 0 && k > 0);
            end
            2: return (k % (2 * W)) >= W;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        logic st;
        if (reset) begin
            m_prev = rate_bit; m_mode = 0; m_k = 0;
            m_pat = '0; m_dir = 1'b0; m_pulse = 1'b0;
`ifdef LED_PWM_EN
            m_pwm = 0;
`endif
        end else begin
`ifdef LED_PWM_EN
            m_pwm = (m_pwm + 1) % 8;
`endif
            st = rate_bit && !m_prev && !pause;
            m_prev = rate_bit;
            m_pulse = 1'b0;
            if (st) begin
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode);
                    m_k = 0;
                    m_pulse = (mode != 2'b11);
                end else if (m_mode != 3) begin
                    m_k++;
                    m_pulse = 1'b1;
                end
            end
            if (m_mode != 3) begin
                m_pat = model_pat(m_mode, m_k);
                m_dir = model_dir(m_mode, m_k);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [W-1:0] exp_leds;
        exp_leds = m_pat;
`ifdef LED_PWM_EN
        if (m_pwm > int'(brightness)) exp_leds = '0;
`endif
        check("leds", 32'(leds), 32'(exp_leds));
        check("dir", 32'(dir), 32'(m_dir));
        check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic rate_pulses(int n);
        for (int i = 0; i < n; i++) begin
            rate_bit = 1'b1; tick(); tick();
            rate_bit = 1'b0; tick(); tick();
        end
    endtask

    initial begin
        tick(); tick();
        check("reset_leds", 32'(leds), 32'h0);
        reset = 1'b0;
        tick();

        // Binary count and wrap.
        rate_bit = 1'b1; tick();
        check("bin_first_pulse", 32'(step_pulse), 32'h1);
        check("bin_first", 32'(leds), 32'h01);
        tick(); check("bin_pulse_one_cycle", 32'(step_pulse), 32'h0);
        rate_bit = 1'b0; tick(); tick();
        rate_pulses(2);
        check("bin_three", 32'(leds), 32'h03);
        rate_pulses(252);
        check("bin_ff", 32'(leds), 32'hFF);
        rate_pulses(1);
        check("bin_wrap", 32'(leds), 32'h00);

        // Bounce scan.
        mode = 2'b01;
        rate_pulses(1);
        check("bounce_load", 32'(leds), 32'h01);
        rate_pulses(7);
        check("bounce_top", 32'(leds), 32'h80);
        check("bounce_top_dir", 32'(dir), 32'h0);
        rate_pulses(1);
        check("bounce_turn", 32'(leds), 32'h40);
        check("bounce_turn_dir", 32'(dir), 32'h1);
        rate_pulses(6);
        check("bounce_bottom", 32'(leds), 32'h01);
        rate_pulses(1);
        check("bounce_up", 32'(leds), 32'h02);
        check("bounce_up_dir", 32'(dir), 32'h0);

        // Fill/drain.
        mode = 2'b10;
        rate_pulses(1);
        check("fill_load", 32'(leds), 32'h00);
        rate_pulses(8);
        check("fill_full", 32'(leds), 32'hFF);
        check("fill_full_dir", 32'(dir), 32'h1);
        rate_pulses(7);
        check("drain_80", 32'(leds), 32'h80);
        rate_pulses(1);
        check("drain_empty", 32'(leds), 32'h00);
        check("drain_empty_dir", 32'(dir), 32'h0);

        // Pause: discarded steps, and dropping pause while rate_bit is high.
        pause = 1'b1;
        rate_pulses(3);
        check("pause_frozen", 32'(leds), 32'h00);
        rate_bit = 1'b1; tick();
        pause = 1'b0; tick(); tick();
        check("pause_release_no_step", 32'(step_pulse), 32'h0);
        rate_bit = 1'b0; tick(); tick();
        rate_pulses(1);
        check("after_pause", 32'(leds), 32'h01);

        // Hold.
        mode = 2'b11;
        rate_pulses(2);
        check("hold_frozen", 32'(leds), 32'h01);

        // Reset mid-bounce coinciding with a rate edge, rate_bit held high through release.
        mode = 2'b01;
        rate_pulses(7);
        check("pre_reset", 32'(leds), 32'h40);
        rate_bit = 1'b1; reset = 1'b1; tick();
        check("reset_mid_leds", 32'(leds), 32'h00);
        tick(); reset = 1'b0; tick(); tick();
        check("reset_release_no_step", 32'(leds), 32'h00);
        rate_bit = 1'b0; tick();

        // Randomized stimulus.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 2) == 0) rate_bit = ~rate_bit;
            pause = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 399) == 0);
`ifdef LED_PWM_EN
            if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
